// File: rtl/rc4_seq_pkg.sv
// rc4_seq_pkg: shared state encoding, DONE reason codes and width helper for the RC4 key-search sequencer.
package rc4_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_NEXT, S_DONE} seq_state_t;
  localparam logic [1:0] RSN_NONE = 2'd0, RSN_FOUND = 2'd1, RSN_ABORT = 2'd2, RSN_TIMEOUT = 2'd3;
  function automatic int sel_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/rc4_keysearch_sequencer_watchdog.sv
// rc4_phase_watchdog: per-phase WAIT cycle counter; expired marks the last allowed WAIT cycle.
module rc4_phase_watchdog import rc4_seq_pkg::*; #(
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  if (TIMEOUT_CYC == 0) begin : g_off
    logic unused;
    assign unused = ^{clk, rst_n, clr, en};
    assign expired = 1'b0;
  end else begin : g_on
    localparam int CW = sel_w(TIMEOUT_CYC);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk)
      if (!rst_n || clr) cnt <= '0;
      else if (en) cnt <= cnt + CW'(1);
    assign expired = cnt == CW'(TIMEOUT_CYC - 1);
  end
endmodule

// File: rtl/rc4_keysearch_sequencer.sv
// rc4_keysearch_sequencer: steps one RC4 core through its phases for each key candidate of a strided key range.
module rc4_keysearch_sequencer import rc4_seq_pkg::*; #(
  parameter int NUM_PHASES  = 4,
  parameter int KEY_W       = 24,
  parameter int KEY_FIRST   = 0,
  parameter int KEY_LAST    = 2**24 - 1,
  parameter int KEY_STEP    = 1,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            go,
  input  logic                            restart,
  input  logic                            stop,
  input  logic [NUM_PHASES-1:0]           phase_finish,
  input  logic                            result_valid,
  output logic [NUM_PHASES-1:0]           phase_start,
  output logic [sel_w(NUM_PHASES)-1:0]    mem_sel,
  output logic [KEY_W-1:0]                cur_key,
  output logic                            busy,
  output logic                            done,
  output logic                            key_found,
  output logic                            aborted,
  output logic                            timeout_err
);
  localparam int SW = sel_w(NUM_PHASES);
  localparam logic [KEY_W:0] STEP_X = (KEY_W+1)'(KEY_STEP);
  localparam logic [KEY_W:0] LAST_X = (KEY_W+1)'(KEY_LAST);
  localparam logic [KEY_W-1:0] FIRST_K = KEY_W'(KEY_FIRST);
  seq_state_t state, state_n;
  logic [SW-1:0] phase, phase_n;
  logic [KEY_W-1:0] key_n;
  logic [1:0] rsn, rsn_n;
  logic [NUM_PHASES-1:0] sel_oh;
  logic [KEY_W:0] key_inc;
  logic fin, last, found, wd_exp;
  assign sel_oh = NUM_PHASES'(1) << phase;
  assign fin = |(phase_finish & sel_oh);
  assign last = phase == SW'(NUM_PHASES - 1);
  assign found = fin && last && result_valid;
  assign key_inc = {1'b0, cur_key} + STEP_X;
  rc4_phase_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk(clk), .rst_n(rst_n), .clr(state == S_START), .en(state == S_WAIT), .expired(wd_exp)
  );
  // Same-cycle priority: found > stop > timeout > ordinary finish.
  always_comb begin
    state_n = state;
    phase_n = phase;
    key_n = cur_key;
    rsn_n = rsn;
    case (state)
      S_IDLE: if (go) begin
        state_n = S_START;
        phase_n = '0;
        key_n = FIRST_K;
        rsn_n = RSN_NONE;
      end
      S_START: begin
        state_n = stop ? S_DONE : S_WAIT;
        rsn_n = stop ? RSN_ABORT : rsn;
      end
      S_WAIT: if (found) begin
        state_n = S_DONE;
        rsn_n = RSN_FOUND;
      end else if (stop || wd_exp) begin
        state_n = S_DONE;
        rsn_n = stop ? RSN_ABORT : RSN_TIMEOUT;
      end else if (fin) begin
        state_n = last ? S_NEXT : S_START;
        phase_n = last ? phase : phase + SW'(1);
      end
      S_NEXT: if (stop) begin
        state_n = S_DONE;
        rsn_n = RSN_ABORT;
      end else if (key_inc > LAST_X) state_n = S_DONE;
      else begin
        state_n = S_START;
        phase_n = '0;
        key_n = key_inc[KEY_W-1:0];
      end
      S_DONE: if (restart) begin
        state_n = S_IDLE;
        rsn_n = RSN_NONE;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= S_IDLE;
      phase <= '0;
      cur_key <= FIRST_K;
      rsn <= RSN_NONE;
    end else begin
      state <= state_n;
      phase <= phase_n;
      cur_key <= key_n;
      rsn <= rsn_n;
    end
  assign phase_start = state == S_START ? sel_oh : '0;
  assign mem_sel = (state == S_START || state == S_WAIT) ? phase + SW'(1) : '0;
  assign busy = state == S_START || state == S_WAIT || state == S_NEXT;
  assign done = state == S_DONE;
  assign key_found = rsn == RSN_FOUND;
  assign aborted = rsn == RSN_ABORT;
  assign timeout_err = rsn == RSN_TIMEOUT;
endmodule

// File: tb/tb_rc4_keysearch_sequencer.sv
// tb_rc4_keysearch_sequencer: drives reactive phase engines and checks the sequencer against a timeline model.
module tb_rc4_keysearch_sequencer;
  localparam int N = 4, KW = 4, KF = 1, KL = 15, KS = 2, T = 8;
  localparam int NK = (KL - KF) / KS + 1;
  localparam int SW = $clog2(N + 1);
  localparam int O_NONE = 0, O_FOUND = 1, O_ABORT = 2, O_TIMEOUT = 3;
  logic clk = 0, rst_n = 0, go = 0, restart = 0, stop = 0, result_valid = 0;
  logic [N-1:0] phase_finish = '0;
  logic [N-1:0] phase_start;
  logic [SW-1:0] mem_sel;
  logic [KW-1:0] cur_key;
  logic busy, done, key_found, aborted, timeout_err;
  int checks = 0, errors = 0;
  typedef struct {int cyc; int key; int ph;} start_t;
  always #5 clk = ~clk;
  rc4_keysearch_sequencer #(
    .NUM_PHASES(N), .KEY_W(KW), .KEY_FIRST(KF), .KEY_LAST(KL), .KEY_STEP(KS), .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .restart(restart), .stop(stop),
    .phase_finish(phase_finish), .result_valid(result_valid), .phase_start(phase_start),
    .mem_sel(mem_sel), .cur_key(cur_key), .busy(busy), .done(done),
    .key_found(key_found), .aborted(aborted), .timeout_err(timeout_err)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  // Model: each phase costs 1 START cycle plus its finish delay; NEXT adds one cycle per key.
  task automatic run(input string nm, input int valid_key, input int dmin, input int dmax,
                     input int hang_ki, input int hang_p, input int stop_at);
    int dly[NK][N];
    start_t q[$];
    int t, outcome, fin, fkey, qi, cnt, eng_p, eng_fv, done_cyc, key, d;
    bit fv;
    for (int k = 0; k < NK; k++)
      for (int p = 0; p < N; p++)
        dly[k][p] = (k == hang_ki && p == hang_p) ? 999 : int'($urandom_range(dmax, dmin));
    t = 0;
    outcome = O_NONE;
    fin = -1;
    for (int k = 0; k < NK && fin < 0; k++) begin
      key = KF + k * KS;
      for (int p = 0; p < N && fin < 0; p++) begin
        d = dly[k][p];
        fv = (p == N - 1) && (key == valid_key);
        q.push_back('{t, key, p});
        if (d >= T && !(fv && d == T)) begin
          outcome = O_TIMEOUT;
          fin = t + T;
        end else if (fv) begin
          outcome = O_FOUND;
          fin = t + d;
        end else t += d + 1;
      end
      if (fin < 0 && k == NK - 1) fin = t;
      t += 1;
    end
    if (stop_at >= 0 && stop_at <= fin && !(outcome == O_FOUND && stop_at == fin)) begin
      outcome = O_ABORT;
      fin = stop_at;
      while (q[q.size()-1].cyc > stop_at) void'(q.pop_back());
    end
    fkey = q[q.size()-1].key;
    go = 1;
    tick;
    go = 0;
    qi = 0;
    cnt = 0;
    eng_p = 0;
    eng_fv = 0;
    done_cyc = -1;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin
        done_cyc = c;
        break;
      end
      if (phase_start != 0) begin
        if (qi < q.size()) begin
          chk({nm, "_start_cyc"}, c, q[qi].cyc);
          chk({nm, "_start_key"}, cur_key, q[qi].key);
          chk({nm, "_start_onehot"}, phase_start, 1 << q[qi].ph);
          chk({nm, "_start_mem_sel"}, mem_sel, q[qi].ph + 1);
          eng_p = q[qi].ph;
          cnt = dly[(q[qi].key - KF) / KS][eng_p];
          eng_fv = int'(eng_p == N - 1 && q[qi].key == valid_key);
          qi++;
        end else chk({nm, "_extra_start"}, phase_start, 0);
      end
      phase_finish = N'($urandom) & ~(N'(1) << eng_p);
      result_valid = 1'($urandom);
      if (phase_start == 0 && cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          phase_finish[eng_p] = 1'b1;
          result_valid = 1'(eng_fv);
        end
      end
      stop = (c == stop_at);
      tick;
    end
    phase_finish = '0;
    result_valid = 0;
    stop = 0;
    chk({nm, "_done_cycle"}, done_cyc, fin + 1);
    chk({nm, "_starts_seen"}, qi, q.size());
    chk({nm, "_key_found"}, key_found, outcome == O_FOUND);
    chk({nm, "_aborted"}, aborted, outcome == O_ABORT);
    chk({nm, "_timeout_err"}, timeout_err, outcome == O_TIMEOUT);
    chk({nm, "_cur_key"}, cur_key, fkey);
    chk({nm, "_mem_sel_done"}, mem_sel, 0);
    chk({nm, "_busy_done"}, busy, 0);
  endtask
  task automatic do_restart(input string nm, input int key);
    go = 1;
    tick;
    go = 0;
    chk({nm, "_go_ignored_in_done"}, done, 1);
    restart = 1;
    tick;
    restart = 0;
    chk({nm, "_restart_done"}, done, 0);
    chk({nm, "_restart_busy"}, busy, 0);
    chk({nm, "_restart_flags"}, {key_found, aborted, timeout_err}, 0);
    chk({nm, "_restart_key"}, cur_key, key);
  endtask
  initial begin
    tick;
    tick;
    chk("rst_phase_start", phase_start, 0);
    chk("rst_mem_sel", mem_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {key_found, aborted, timeout_err}, 0);
    chk("rst_cur_key", cur_key, KF);
    rst_n = 1;
    tick;
    chk("idle_busy", busy, 0);
    run("t1_fixed3", KF, 3, 3, -1, -1, -1);
    do_restart("r1", KF);
    run("t2_found7", 7, 1, 5, -1, -1, -1);
    do_restart("r2", 7);
    run("t3_exhaust", -1, 1, 4, -1, -1, -1);
    do_restart("r3", KL);
    run("t4_hang", -1, 1, 4, 1, 2, -1);
    do_restart("r4", 3);
    run("t4_d_eq_t", -1, T, T, -1, -1, -1);
    do_restart("r4b", KF);
    run("t4_d_t_minus1", 3, T - 1, T - 1, -1, -1, -1);
    do_restart("r4c", 3);
    run("t5_stop_wait", -1, 2, 2, -1, -1, 28);
    do_restart("r5", 5);
    run("t5_stop_vs_found", 3, 2, 2, -1, -1, 24);
    do_restart("r5b", 3);
    go = 1;
    tick;
    go = 0;
    tick;
    tick;
    chk("t6_in_wait", busy, 1);
    rst_n = 0;
    tick;
    chk("t6_rst_phase_start", phase_start, 0);
    chk("t6_rst_mem_sel", mem_sel, 0);
    chk("t6_rst_busy_done", {busy, done}, 0);
    chk("t6_rst_flags", {key_found, aborted, timeout_err}, 0);
    chk("t6_rst_cur_key", cur_key, KF);
    rst_n = 1;
    tick;
    run("t6_rerun", 9, 1, 6, -1, -1, -1);
    for (int i = 0; i < 6; i++) begin
      int vk, sa;
      do_restart("rr", cur_key);
      vk = ($urandom_range(3, 0) == 0) ? -1 : KF + KS * int'($urandom_range(NK - 1, 0));
      sa = ($urandom_range(1, 0) == 0) ? -1 : int'($urandom_range(80, 0));
      run($sformatf("rnd%0d", i), vk, 1, 9, -1, -1, sa);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
